usb_tx_arbiter: RTL

Sequences and shares the single device-to-host transmit path between endpoint 0 and endpoint 1. When the packet interface opens a response window, the block grants one requesting endpoint using round-robin, latches its PID and length, and streams its buffer one byte per accepted beat. The host side uses a valid/ready handshake. It sits between the endpoint TX buffers and the host-facing packet interface, and replaces ad-hoc per-endpoint streaming loops with a synthesizable FSM.

---
 rtl/usb_defs_pkg.sv | 25 ++
 rtl/usb_rr_arb2.sv | 14 +
 rtl/usb_tx_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/usb_defs_pkg.sv
// usb_defs_pkg: shared USB transmit definitions.
//   PID_DATA0/PID_DATA1 : data packet PIDs
//   EP0/EP1             : endpoint ids used for grant and last_grant
//   EP_MAX_PKT          : largest packet the transmit path will stream
//   tx_arb_state_t      : transmit arbiter FSM states
//   clamp_len           : limits a requested byte count to a maximum
package usb_defs_pkg;

    localparam logic [3:0] PID_DATA0  = 4'h3;
    localparam logic [3:0] PID_DATA1  = 4'hB;
    localparam logic       EP0        = 1'b0;
    localparam logic       EP1        = 1'b1;
    localparam int         EP_MAX_PKT = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } tx_arb_state_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/usb_rr_arb2.sv
// usb_rr_arb2: two-way round-robin picker.
//   req        : request vector, bit N = endpoint N
//   last_grant : endpoint granted most recently
//   grant_out  : chosen endpoint; a lone requester wins, a tie goes to the
//                endpoint that was not granted last
module usb_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_out
);

    assign grant_out = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: shares the device-to-host transmit path between EP0 and EP1.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   tx_window                  : response window open; arbitration only while high
//   host_abort                 : abandon the packet being streamed
//   epN_tx_req/pid/len         : endpoint packet request, PID and byte count
//   epN_rd_addr / epN_rd_data  : endpoint buffer read port (combinational data)
//   epN_tx_done / epN_tx_abort : one-cycle completion / abort pulses
//   host_tx_*                  : valid/ready byte stream toward the host
//   len_err                    : one-cycle pulse when a granted length was clamped
module usb_tx_arbiter
    import usb_defs_pkg::*;
#(
    parameter int MAX_PKT = EP_MAX_PKT,
    parameter int ADDR_W  = $clog2(MAX_PKT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_window,
    input  logic              host_abort,
    input  logic              ep0_tx_req,
    input  logic [3:0]        ep0_tx_pid,
    input  logic [15:0]       ep0_tx_len,
    output logic [ADDR_W-1:0] ep0_rd_addr,
    input  logic [7:0]        ep0_rd_data,
    output logic              ep0_tx_done,
    output logic              ep0_tx_abort,
    input  logic              ep1_tx_req,
    input  logic [3:0]        ep1_tx_pid,
    input  logic [15:0]       ep1_tx_len,
    output logic [ADDR_W-1:0] ep1_rd_addr,
    input  logic [7:0]        ep1_rd_data,
    output logic              ep1_tx_done,
    output logic              ep1_tx_abort,
    output logic              host_tx_valid,
    input  logic              host_tx_ready,
    output logic [3:0]        host_tx_pid,
    output logic [7:0]        host_tx_data,
    output logic [15:0]       host_tx_len,
    output logic              host_tx_sop,
    output logic              host_tx_eop,
    output logic              len_err
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PKT);

    tx_arb_state_t     state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [3:0]        pid_q, pid_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              len_err_q, len_err_d;
    logic              abort_q, abort_d;
    logic              pick;
    logic [15:0]       req_len;
    logic              streaming;
    logic              eop;
    logic [7:0]        rd_byte;

    usb_rr_arb2 u_arb (
        .req        ({ep1_tx_req, ep0_tx_req}),
        .last_grant (last_q),
        .grant_out  (pick)
    );

    assign streaming = (state_q == S_STREAM);
    // A zero-length packet still needs one beat, so it is eop from the start.
    assign eop       = (len_q == 16'd0) || (16'(idx_q) == len_q - 16'd1);
    assign rd_byte   = grant_q ? ep1_rd_data : ep0_rd_data;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pid_d     = pid_q;
        len_d     = len_q;
        idx_d     = idx_q;
        len_err_d = 1'b0;
        abort_d   = 1'b0;
        req_len   = pick ? ep1_tx_len : ep0_tx_len;
        case (state_q)
            S_IDLE: begin
                if (tx_window && (ep0_tx_req || ep1_tx_req)) begin
                    grant_d   = pick;
                    pid_d     = pick ? ep1_tx_pid : ep0_tx_pid;
                    len_d     = clamp_len(req_len, MAX_LEN);
                    len_err_d = (req_len > MAX_LEN);
                    idx_d     = '0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                // Abort wins over a simultaneous accept; last_grant is left alone
                // so the aborted endpoint is first in line for the retry.
                if (host_abort) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (host_tx_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (eop) state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= EP0;
            last_q    <= EP1;
            pid_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            len_err_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pid_q     <= pid_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            len_err_q <= len_err_d;
            abort_q   <= abort_d;
        end
    end

    assign host_tx_valid = streaming;
    assign host_tx_pid   = pid_q;
    assign host_tx_len   = len_q;
    assign host_tx_data  = (streaming && len_q != 16'd0) ? rd_byte : 8'h00;
    assign host_tx_sop   = streaming && (idx_q == '0);
    assign host_tx_eop   = streaming && eop;
    assign ep0_rd_addr   = (streaming && grant_q == EP0) ? idx_q[ADDR_W-1:0] : '0;
    assign ep1_rd_addr   = (streaming && grant_q == EP1) ? idx_q[ADDR_W-1:0] : '0;
    assign ep0_tx_done   = (state_q == S_DONE) && (grant_q == EP0);
    assign ep1_tx_done   = (state_q == S_DONE) && (grant_q == EP1);
    assign ep0_tx_abort  = abort_q && (grant_q == EP0);
    assign ep1_tx_abort  = abort_q && (grant_q == EP1);
    assign len_err       = len_err_q;

endmodule
